// File: rtl/vedic_mul_pipe_if.sv
// Valid/ready operand and result bundle for vedic_mul_pipe.
// The producer/consumer side uses master; the multiplier uses slave.
interface vedic_mul_pipe_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
);
    logic                 IN_VALID;
    logic                 IN_READY;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 SIGNED_EN;
    logic [TAG_W-1:0]     IN_TAG;
    logic                 OUT_VALID;
    logic                 OUT_READY;
    logic [2*WIDTH-1:0]   Q;
    logic [TAG_W-1:0]     OUT_TAG;

    modport master (
        output IN_VALID, A, B, SIGNED_EN, IN_TAG, OUT_READY,
        input  IN_READY, OUT_VALID, Q, OUT_TAG
    );

    modport slave (
        input  IN_VALID, A, B, SIGNED_EN, IN_TAG, OUT_READY,
        output IN_READY, OUT_VALID, Q, OUT_TAG
    );
endinterface

// File: rtl/vedic_mul_pipe.sv
// Three-stage pipelined Urdhva-Tiryagbhyam multiplier, signed/unsigned per beat,
// valid/ready on both sides with a global stall on output backpressure.

// Recursive combinational Vedic core: splits down to 2x2 bit cells.
module vedic_mul_core #(
    parameter int N = 4
) (
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [2*N-1:0] p_o
);
    if (N == 2) begin : gen_cell
        logic x1, x2, hh, c1;
        assign x1     = a_i[1] & b_i[0];
        assign x2     = a_i[0] & b_i[1];
        assign hh     = a_i[1] & b_i[1];
        assign c1     = x1 & x2;
        assign p_o[0] = a_i[0] & b_i[0];
        assign p_o[1] = x1 ^ x2;
        assign p_o[2] = hh ^ c1;
        assign p_o[3] = hh & c1;
    end else begin : gen_split
        localparam int M = N / 2;
        logic [N-1:0]   q0, q1, q2, q3;
        logic [N-1:0]   pp0;
        logic [3*M-1:0] pp1, upper;

        vedic_mul_core #(.N(M)) u_q0 (.a_i(a_i[M-1:0]), .b_i(b_i[M-1:0]), .p_o(q0));
        vedic_mul_core #(.N(M)) u_q1 (.a_i(a_i[N-1:M]), .b_i(b_i[M-1:0]), .p_o(q1));
        vedic_mul_core #(.N(M)) u_q2 (.a_i(a_i[M-1:0]), .b_i(b_i[N-1:M]), .p_o(q2));
        vedic_mul_core #(.N(M)) u_q3 (.a_i(a_i[N-1:M]), .b_i(b_i[N-1:M]), .p_o(q3));

        assign pp0   = q1 + {{M{1'b0}}, q0[N-1:M]};
        assign pp1   = {q3, {M{1'b0}}} + {{M{1'b0}}, q2};
        assign upper = {{M{1'b0}}, pp0} + pp1;
        assign p_o   = {upper, q0[M-1:0]};
    end
endmodule

module vedic_mul_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic          CLK,
    input  logic          RST_n,
    vedic_mul_pipe_if.slave bus
);
    localparam int H = WIDTH / 2;

    logic               stall;
    logic               neg_d;
    logic [WIDTH-1:0]   a_mag_d, b_mag_d;

    logic               s1_valid_q, s1_neg_q;
    logic [WIDTH-1:0]   s1_a_q, s1_b_q;
    logic [TAG_W-1:0]   s1_tag_q;

    logic [2*H-1:0]     q0_d, q1_d, q2_d, q3_d;
    logic               s2_valid_q, s2_neg_q;
    logic [2*H-1:0]     s2_q0_q, s2_q1_q, s2_q2_q, s2_q3_q;
    logic [TAG_W-1:0]   s2_tag_q;

    logic [2*H-1:0]     pp0;
    logic [3*H-1:0]     pp1, upper;
    logic [2*WIDTH-1:0] p_d, q_d;

    logic               out_valid_q;
    logic [2*WIDTH-1:0] q_q;
    logic [TAG_W-1:0]   out_tag_q;

    // A full output register that is not being taken freezes the whole pipe.
    assign stall        = out_valid_q && !bus.OUT_READY;
    assign bus.IN_READY = !stall;

    always_comb begin
        neg_d   = bus.SIGNED_EN & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
        a_mag_d = (bus.SIGNED_EN && bus.A[WIDTH-1]) ? -bus.A : bus.A;
        b_mag_d = (bus.SIGNED_EN && bus.B[WIDTH-1]) ? -bus.B : bus.B;
    end

    vedic_mul_core #(.N(H)) u_q0 (.a_i(s1_a_q[H-1:0]),     .b_i(s1_b_q[H-1:0]),     .p_o(q0_d));
    vedic_mul_core #(.N(H)) u_q1 (.a_i(s1_a_q[WIDTH-1:H]), .b_i(s1_b_q[H-1:0]),     .p_o(q1_d));
    vedic_mul_core #(.N(H)) u_q2 (.a_i(s1_a_q[H-1:0]),     .b_i(s1_b_q[WIDTH-1:H]), .p_o(q2_d));
    vedic_mul_core #(.N(H)) u_q3 (.a_i(s1_a_q[WIDTH-1:H]), .b_i(s1_b_q[WIDTH-1:H]), .p_o(q3_d));

    always_comb begin
        pp0   = s2_q1_q + {{H{1'b0}}, s2_q0_q[2*H-1:H]};
        pp1   = {s2_q3_q, {H{1'b0}}} + {{H{1'b0}}, s2_q2_q};
        upper = {{H{1'b0}}, pp0} + pp1;
        p_d   = {upper, s2_q0_q[H-1:0]};
        q_d   = s2_neg_q ? -p_d : p_d;
    end

    // NOTE: state uses non-blocking assignments so every stage samples the
    // previous stage's old value on the same edge.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            s1_valid_q  <= 1'b0;
            s1_neg_q    <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_neg_q    <= 1'b0;
            s2_q0_q     <= '0;
            s2_q1_q     <= '0;
            s2_q2_q     <= '0;
            s2_q3_q     <= '0;
            s2_tag_q    <= '0;
            out_valid_q <= 1'b0;
            q_q         <= '0;
            out_tag_q   <= '0;
        end else if (!stall) begin
            s1_valid_q  <= bus.IN_VALID;
            s1_neg_q    <= neg_d;
            s1_a_q      <= a_mag_d;
            s1_b_q      <= b_mag_d;
            s1_tag_q    <= bus.IN_TAG;
            s2_valid_q  <= s1_valid_q;
            s2_neg_q    <= s1_neg_q;
            s2_q0_q     <= q0_d;
            s2_q1_q     <= q1_d;
            s2_q2_q     <= q2_d;
            s2_q3_q     <= q3_d;
            s2_tag_q    <= s1_tag_q;
            out_valid_q <= s2_valid_q;
            q_q         <= q_d;
            out_tag_q   <= s2_tag_q;
        end
    end

    assign bus.OUT_VALID = out_valid_q;
    assign bus.Q         = q_q;
    assign bus.OUT_TAG   = out_tag_q;
endmodule
